crossing_fsm: RTL and testbench
===============================

Name: crossing_fsm

Overview:
- Game-logic core of the cat/dog/mouse river-crossing game.
- Sits between the debounce/divider stages (upstream) and the dot-matrix/7-segment scanning stage (downstream).
- Consumes debounced button levels and the divided tick signals; produces bank positions, boarding/crossing flags, move counters, BCD countdown digits, difficulty and game state for display.

Parameters:
- EASY_TIME, 60, countdown start in seconds when sw5=0 (BCD-representable, ≤99)
- HARD_TIME, 30, countdown start in seconds when sw5=1
- CROSS_TICKS, 4, clk_4Hz rising edges per canoe crossing

Ports:
- clk_1kHz  in  1  system clock; all logic on its rising edge
- btn_0_out  in  1  synchronous active-high reset (debounced btn_0)
- clk_1Hz  in  1  divided 1 Hz level; rising edge detected internally
- clk_4Hz  in  1  divided 4 Hz level; rising edge detected internally
- sw6  in  1  game enable: 0 = idle/hold, 1 = play
- sw5  in  1  difficulty select, sampled only in IDLE
- btn_7_out, btn_6_out, btn_5_out, btn_4_out  in  1 each  debounced cat/dog/mouse/canoe buttons; a press is a 0→1 edge
- cat_position, dog_position, mouse_position, canoe_position  out  1 each  0 = left bank, 1 = right bank
- cat_crossing, dog_crossing, mouse_crossing  out  1 each  animal selected as canoe passenger
- canoe_crossing  out  1  canoe in transit
- cnt_cat, cnt_dog, cnt_mouse  out  2 each  per-animal trips, saturate at 3
- cnt_canoe  out  4  canoe trips, saturate at 15
- ones, tens  out  4 each  BCD seconds remaining
- gameDifficulty  out  2  0 = easy, 1 = hard
- gameState  out  2  0 = fail, 1 = success, 2 = continue

Behaviour:
- Reset (btn_0_out=1 at a clock edge) has priority over everything, including mid-crossing. After reset:
  - positions 0, crossing flags 0, counters 0
  - tens/ones = EASY_TIME digits (6/0), gameDifficulty 0, gameState 2
  - state IDLE; edge-detect registers loaded with current input levels, so no spurious press or tick follows reset
- Edge detect: one registered copy per button and tick; a pulse is current & ~previous. At most one pulse per event.
- IDLE:
  - gameDifficulty = {1'b0, sw5}; ones/tens preset from EASY_TIME or HARD_TIME every cycle.
  - sw6=1 → PLAY.
- PLAY:
  - Animal press with animal on the canoe bank → toggle that animal's crossing flag; any other flag is cleared (max one passenger).
  - Animal press with animal on the opposite bank → ignored.
  - Canoe press → CROSS, canoe_crossing=1, tick counter cleared.
  - When the canoe press coincides with an animal press, the animal press is applied first and the canoe press is ignored that cycle.
- CROSS:
  - Button presses ignored.
  - After CROSS_TICKS clk_4Hz edges: canoe_position and the passenger's position toggle; passenger flag clears; canoe_crossing=0; cnt_canoe and passenger counter increment (saturating).
  - Then evaluate, in this order:
    - all four positions = 1 → WIN
    - canoe bank ≠ bank where cat and mouse are both present → LOSE
    - canoe bank ≠ bank where dog and cat are both present → LOSE
    - otherwise → PLAY
- Timer (PLAY and CROSS only):
  - On each clk_1Hz edge, decrement BCD: ones 0 → 9 with tens−1.
  - Reaching 00 → LOSE immediately, even mid-crossing; transit is abandoned and canoe_crossing clears.
  - Never wraps below 00.
- WIN: gameState=1. LOSE: gameState=0. In both, all outputs are frozen and inputs are ignored until reset.
- sw6=0 in PLAY or CROSS: return to IDLE with positions, flags and counters cleared.
- gameState=2 in IDLE/PLAY/CROSS.
- Latency: outputs are registered and change one clock after the triggering edge-detect pulse.

Test Plan:
- Reset, sw5=1, sw6=1 → tens/ones=3/0, gameDifficulty=1, gameState=2, all positions 0.
- Press btn_7 then btn_4, wait 4 clk_4Hz edges → cat_position=1, canoe_position=1, cnt_cat=1, cnt_canoe=1, gameState=2.
- Press btn_6 (dog) then btn_4 from the start → dog reaches right; cat+mouse left without canoe → gameState=0, outputs frozen.
- Full solve (cat over, empty back, dog over, cat back, mouse over, empty back, cat over) → all positions 1, cnt_canoe=7, cnt_cat=3, gameState=1.
- Play without moves for 30 clk_1Hz edges on hard → tens/ones steps 3/0, 2/9 … 0/0, then gameState=0. Assert reset mid-crossing → canoe_crossing=0 next clock, positions 0.
- btn_7 and btn_4 pulses in the same cycle → cat_crossing=1, no crossing starts. Press the mouse button with the mouse off the canoe bank → no flag change.

Source files
------------

// File: rtl/crossing_fsm.sv
// rtl/crossing_fsm.sv - game-logic core of the cat/dog/mouse river-crossing puzzle
module crossing_fsm #(
    parameter int EASY_TIME   = 60,
    parameter int HARD_TIME   = 30,
    parameter int CROSS_TICKS = 4
) (
    input  logic       clk_1kHz,
    input  logic       btn_0_out,
    input  logic       clk_1Hz,
    input  logic       clk_4Hz,
    input  logic       sw6,
    input  logic       sw5,
    input  logic       btn_7_out,
    input  logic       btn_6_out,
    input  logic       btn_5_out,
    input  logic       btn_4_out,
    output logic       cat_position,
    output logic       dog_position,
    output logic       mouse_position,
    output logic       canoe_position,
    output logic       cat_crossing,
    output logic       dog_crossing,
    output logic       mouse_crossing,
    output logic       canoe_crossing,
    output logic [1:0] cnt_cat,
    output logic [1:0] cnt_dog,
    output logic [1:0] cnt_mouse,
    output logic [3:0] cnt_canoe,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [1:0] gameDifficulty,
    output logic [1:0] gameState
);
    localparam int TW = $clog2(CROSS_TICKS + 1);
    localparam logic [3:0] EASY_TENS = 4'(EASY_TIME / 10);
    localparam logic [3:0] EASY_ONES = 4'(EASY_TIME % 10);
    localparam logic [3:0] HARD_TENS = 4'(HARD_TIME / 10);
    localparam logic [3:0] HARD_ONES = 4'(HARD_TIME % 10);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CROSS, S_WIN, S_LOSE} state_t;

    state_t        state;
    logic [5:0]    levels;
    logic [5:0]    prev;
    logic [5:0]    pulse;
    logic [TW-1:0] tick_cnt;
    logic          p_sec, p_tick, p_cat, p_dog, p_mouse, p_canoe;
    logic          n_cat, n_dog, n_mouse, n_canoe;
    logic          win, lose, expire, tick_done;

    assign levels = {clk_1Hz, clk_4Hz, btn_7_out, btn_6_out, btn_5_out, btn_4_out};
    assign pulse  = levels & ~prev;
    assign {p_sec, p_tick, p_cat, p_dog, p_mouse, p_canoe} = pulse;

    // Bank layout once the current crossing lands, used to judge the outcome.
    always_comb begin
        n_canoe   = ~canoe_position;
        n_cat     = cat_position ^ cat_crossing;
        n_dog     = dog_position ^ dog_crossing;
        n_mouse   = mouse_position ^ mouse_crossing;
        win       = n_cat & n_dog & n_mouse & n_canoe;
        lose      = ((n_cat == n_mouse) && (n_canoe != n_cat)) ||
                    ((n_dog == n_cat) && (n_canoe != n_cat));
        expire    = p_sec && (tens == 4'd0) && (ones == 4'd1);
        tick_done = p_tick && (tick_cnt == TW'(CROSS_TICKS - 1));
    end

    function automatic logic [1:0] sat2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out) begin
            state          <= S_IDLE;
            prev           <= levels;
            tick_cnt       <= '0;
            cat_position   <= 1'b0;
            dog_position   <= 1'b0;
            mouse_position <= 1'b0;
            canoe_position <= 1'b0;
            cat_crossing   <= 1'b0;
            dog_crossing   <= 1'b0;
            mouse_crossing <= 1'b0;
            canoe_crossing <= 1'b0;
            cnt_cat        <= 2'd0;
            cnt_dog        <= 2'd0;
            cnt_mouse      <= 2'd0;
            cnt_canoe      <= 4'd0;
            tens           <= EASY_TENS;
            ones           <= EASY_ONES;
            gameDifficulty <= 2'd0;
            gameState      <= 2'd2;
        end else begin
            prev <= levels;
            case (state)
                S_IDLE: begin
                    gameDifficulty <= {1'b0, sw5};
                    tens           <= sw5 ? HARD_TENS : EASY_TENS;
                    ones           <= sw5 ? HARD_ONES : EASY_ONES;
                    if (sw6) state <= S_PLAY;
                end
                S_PLAY, S_CROSS: begin
                    if (!sw6) begin
                        state          <= S_IDLE;
                        tick_cnt       <= '0;
                        cat_position   <= 1'b0;
                        dog_position   <= 1'b0;
                        mouse_position <= 1'b0;
                        canoe_position <= 1'b0;
                        cat_crossing   <= 1'b0;
                        dog_crossing   <= 1'b0;
                        mouse_crossing <= 1'b0;
                        canoe_crossing <= 1'b0;
                        cnt_cat        <= 2'd0;
                        cnt_dog        <= 2'd0;
                        cnt_mouse      <= 2'd0;
                        cnt_canoe      <= 4'd0;
                    end else if (expire) begin
                        // Time out wins over any landing or press in the same cycle.
                        tens           <= 4'd0;
                        ones           <= 4'd0;
                        canoe_crossing <= 1'b0;
                        state          <= S_LOSE;
                        gameState      <= 2'd0;
                    end else begin
                        if (p_sec && !(tens == 4'd0 && ones == 4'd0)) begin
                            if (ones == 4'd0) begin
                                ones <= 4'd9;
                                tens <= tens - 4'd1;
                            end else begin
                                ones <= ones - 4'd1;
                            end
                        end
                        if (state == S_PLAY) begin
                            if (p_cat) begin
                                if (cat_position == canoe_position) begin
                                    cat_crossing   <= ~cat_crossing;
                                    dog_crossing   <= 1'b0;
                                    mouse_crossing <= 1'b0;
                                end
                            end else if (p_dog) begin
                                if (dog_position == canoe_position) begin
                                    dog_crossing   <= ~dog_crossing;
                                    cat_crossing   <= 1'b0;
                                    mouse_crossing <= 1'b0;
                                end
                            end else if (p_mouse) begin
                                if (mouse_position == canoe_position) begin
                                    mouse_crossing <= ~mouse_crossing;
                                    cat_crossing   <= 1'b0;
                                    dog_crossing   <= 1'b0;
                                end
                            end else if (p_canoe) begin
                                state          <= S_CROSS;
                                canoe_crossing <= 1'b1;
                                tick_cnt       <= '0;
                            end
                        end else if (tick_done) begin
                            canoe_position <= n_canoe;
                            cat_position   <= n_cat;
                            dog_position   <= n_dog;
                            mouse_position <= n_mouse;
                            cat_crossing   <= 1'b0;
                            dog_crossing   <= 1'b0;
                            mouse_crossing <= 1'b0;
                            canoe_crossing <= 1'b0;
                            cnt_canoe      <= sat4(cnt_canoe);
                            if (cat_crossing)   cnt_cat   <= sat2(cnt_cat);
                            if (dog_crossing)   cnt_dog   <= sat2(cnt_dog);
                            if (mouse_crossing) cnt_mouse <= sat2(cnt_mouse);
                            if (win) begin
                                state     <= S_WIN;
                                gameState <= 2'd1;
                            end else if (lose) begin
                                state     <= S_LOSE;
                                gameState <= 2'd0;
                            end else begin
                                state <= S_PLAY;
                            end
                        end else if (p_tick) begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_crossing_fsm.sv
// tb/tb_crossing_fsm.sv - directed and randomized checks of crossing_fsm against a behavioural model
module tb_crossing_fsm;
    localparam int EASY_TIME   = 60;
    localparam int HARD_TIME   = 30;
    localparam int CROSS_TICKS = 4;
    localparam int M_IDLE = 0, M_PLAY = 1, M_CROSS = 2, M_WIN = 3, M_LOSE = 4;
    localparam int CAT = 0, DOG = 1, MOUSE = 2, CANOE = 3;

    logic       clk = 1'b0;
    logic       btn_0_out = 1'b1, clk_1Hz = 1'b0, clk_4Hz = 1'b0, sw6 = 1'b0, sw5 = 1'b0;
    logic       btn_7_out = 1'b0, btn_6_out = 1'b0, btn_5_out = 1'b0, btn_4_out = 1'b0;
    logic       cat_position, dog_position, mouse_position, canoe_position;
    logic       cat_crossing, dog_crossing, mouse_crossing, canoe_crossing;
    logic [1:0] cnt_cat, cnt_dog, cnt_mouse, gameDifficulty, gameState;
    logic [3:0] cnt_canoe, ones, tens;

    always #5 clk = ~clk;

    crossing_fsm #(.EASY_TIME(EASY_TIME), .HARD_TIME(HARD_TIME), .CROSS_TICKS(CROSS_TICKS)) dut (
        .clk_1kHz(clk), .btn_0_out(btn_0_out), .clk_1Hz(clk_1Hz), .clk_4Hz(clk_4Hz),
        .sw6(sw6), .sw5(sw5), .btn_7_out(btn_7_out), .btn_6_out(btn_6_out),
        .btn_5_out(btn_5_out), .btn_4_out(btn_4_out),
        .cat_position(cat_position), .dog_position(dog_position),
        .mouse_position(mouse_position), .canoe_position(canoe_position),
        .cat_crossing(cat_crossing), .dog_crossing(dog_crossing),
        .mouse_crossing(mouse_crossing), .canoe_crossing(canoe_crossing),
        .cnt_cat(cnt_cat), .cnt_dog(cnt_dog), .cnt_mouse(cnt_mouse), .cnt_canoe(cnt_canoe),
        .ones(ones), .tens(tens), .gameDifficulty(gameDifficulty), .gameState(gameState)
    );

    int checks = 0;
    int errors = 0;

    // Model: positions/counters indexed cat, dog, mouse, canoe; passenger is an index or -1.
    int   m_pos[4];
    int   m_cnt[4];
    int   m_pass, m_secs, m_diff, m_mode, m_ticks, m_transit;
    logic m_prev_sec, m_prev_tick, m_prev_canoe;
    logic m_prev_an[3];

    function automatic int outcome();
        if (m_pos[CAT] == 1 && m_pos[DOG] == 1 && m_pos[MOUSE] == 1 && m_pos[CANOE] == 1)
            return M_WIN;
        for (int b = 0; b < 2; b++)
            if (m_pos[CANOE] != b && m_pos[CAT] == b && (m_pos[MOUSE] == b || m_pos[DOG] == b))
                return M_LOSE;
        return M_PLAY;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 4; i++) begin
            m_pos[i] = 0;
            m_cnt[i] = 0;
        end
        m_pass    = -1;
        m_transit = 0;
        m_ticks   = 0;
    endtask

    task automatic model_step();
        logic an_lvl[3];
        logic ap[3];
        logic ps, pt, pc;
        int   a;
        an_lvl[0] = btn_7_out;
        an_lvl[1] = btn_6_out;
        an_lvl[2] = btn_5_out;
        if (btn_0_out) begin
            clear_board();
            m_secs = EASY_TIME;
            m_diff = 0;
            m_mode = M_IDLE;
            m_prev_sec = clk_1Hz;
            m_prev_tick = clk_4Hz;
            m_prev_canoe = btn_4_out;
            for (int i = 0; i < 3; i++) m_prev_an[i] = an_lvl[i];
            return;
        end
        for (int i = 0; i < 3; i++) begin
            ap[i] = an_lvl[i] & ~m_prev_an[i];
            m_prev_an[i] = an_lvl[i];
        end
        ps = clk_1Hz & ~m_prev_sec;
        pt = clk_4Hz & ~m_prev_tick;
        pc = btn_4_out & ~m_prev_canoe;
        m_prev_sec = clk_1Hz;
        m_prev_tick = clk_4Hz;
        m_prev_canoe = btn_4_out;
        case (m_mode)
            M_IDLE: begin
                m_diff = int'(sw5);
                m_secs = sw5 ? HARD_TIME : EASY_TIME;
                if (sw6) m_mode = M_PLAY;
            end
            M_PLAY, M_CROSS: begin
                if (!sw6) begin
                    clear_board();
                    m_mode = M_IDLE;
                end else if (ps && m_secs == 1) begin
                    m_secs = 0;
                    m_transit = 0;
                    m_mode = M_LOSE;
                end else begin
                    if (ps && m_secs > 0) m_secs--;
                    if (m_mode == M_PLAY) begin
                        a = -1;
                        for (int k = 2; k >= 0; k--) if (ap[k]) a = k;
                        if (a >= 0) begin
                            if (m_pos[a] == m_pos[CANOE]) m_pass = (m_pass == a) ? -1 : a;
                        end else if (pc) begin
                            m_mode = M_CROSS;
                            m_ticks = 0;
                            m_transit = 1;
                        end
                    end else if (pt) begin
                        m_ticks++;
                        if (m_ticks == CROSS_TICKS) begin
                            m_pos[CANOE] = 1 - m_pos[CANOE];
                            if (m_pass >= 0) begin
                                m_pos[m_pass] = 1 - m_pos[m_pass];
                                if (m_cnt[m_pass] < 3) m_cnt[m_pass]++;
                            end
                            if (m_cnt[CANOE] < 15) m_cnt[CANOE]++;
                            m_pass = -1;
                            m_transit = 0;
                            m_mode = outcome();
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [1:0] gs;
        gs = (m_mode == M_WIN) ? 2'd1 : (m_mode == M_LOSE) ? 2'd0 : 2'd2;
        check("positions", 16'({cat_position, dog_position, mouse_position, canoe_position}),
              16'({1'(m_pos[CAT]), 1'(m_pos[DOG]), 1'(m_pos[MOUSE]), 1'(m_pos[CANOE])}));
        check("flags", 16'({cat_crossing, dog_crossing, mouse_crossing, canoe_crossing}),
              16'({m_pass == CAT, m_pass == DOG, m_pass == MOUSE, m_transit != 0}));
        check("counters", 16'({cnt_cat, cnt_dog, cnt_mouse, cnt_canoe}),
              16'({2'(m_cnt[CAT]), 2'(m_cnt[DOG]), 2'(m_cnt[MOUSE]), 4'(m_cnt[CANOE])}));
        check("timer", 16'({tens, ones}), 16'({4'(m_secs / 10), 4'(m_secs % 10)}));
        check("status", 16'({gameDifficulty, gameState}), 16'({2'(m_diff), gs}));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            CAT:     btn_7_out = v;
            DOG:     btn_6_out = v;
            MOUSE:   btn_5_out = v;
            default: btn_4_out = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        cycle();
        set_btn(which, 1'b0);
        cycle();
    endtask

    task automatic tick4(input int n);
        repeat (n) begin
            clk_4Hz = 1'b1;
            cycle();
            clk_4Hz = 1'b0;
            cycle();
        end
    endtask

    task automatic sec1();
        clk_1Hz = 1'b1;
        cycle();
        clk_1Hz = 1'b0;
        cycle();
    endtask

    task automatic do_reset(input logic hard);
        btn_0_out = 1'b1;
        sw5 = hard;
        sw6 = 1'b0;
        cycle();
        btn_0_out = 1'b0;
        sw6 = 1'b1;
        cycle();
    endtask

    initial begin
        int r;
        // Reset values, then hard mode entered with sw6 already high.
        btn_0_out = 1'b1; sw5 = 1'b1; sw6 = 1'b0;
        cycle();
        check("rst_timer", 16'({tens, ones}), 16'h0060);
        check("rst_state", 16'({gameDifficulty, gameState}), 16'h0002);
        btn_0_out = 1'b0; sw6 = 1'b1;
        cycle();
        check("hard_timer", 16'({tens, ones}), 16'h0030);
        check("hard_diff", 16'(gameDifficulty), 16'd1);

        // Cat across, then the full solution.
        press(CAT); press(CANOE); tick4(4);
        check("cat_over", 16'({cat_position, canoe_position, cnt_cat, cnt_canoe, gameState}),
              16'({1'b1, 1'b1, 2'd1, 4'd1, 2'd2}));
        press(CANOE); tick4(4);
        press(DOG); press(CANOE); tick4(4);
        press(CAT); press(CANOE); tick4(4);
        press(MOUSE); press(CANOE); tick4(4);
        press(CANOE); tick4(4);
        press(CAT); press(CANOE); tick4(4);
        check("solve_pos", 16'({cat_position, dog_position, mouse_position, canoe_position}), 16'hf);
        check("solve_cnt", 16'({cnt_cat, cnt_canoe}), 16'({2'd3, 4'd7}));
        check("solve_state", 16'(gameState), 16'd1);
        press(DOG); press(CANOE); sec1(); tick4(4);
        check("win_frozen", 16'({cnt_canoe, tens, ones, gameState}), 16'({4'd7, 4'd3, 4'd0, 2'd1}));

        // Dog first leaves cat and mouse alone.
        do_reset(1'b0);
        press(DOG); press(CANOE); tick4(4);
        check("dog_lose", 16'({dog_position, gameState}), 16'({1'b1, 2'd0}));
        press(CAT); sec1(); tick4(4);
        check("lose_frozen", 16'({cat_position, cat_crossing, tens, ones}), 16'({1'b0, 1'b0, 4'd6, 4'd0}));

        // Simultaneous cat and canoe presses, then mouse on the far bank.
        do_reset(1'b0);
        btn_7_out = 1'b1; btn_4_out = 1'b1;
        cycle();
        btn_7_out = 1'b0; btn_4_out = 1'b0;
        cycle();
        check("coincide", 16'({cat_crossing, canoe_crossing}), 16'b10);
        press(CANOE); tick4(4);
        press(MOUSE);
        check("mouse_far", 16'({mouse_crossing, cat_position}), 16'b01);

        // Countdown on hard to expiry.
        do_reset(1'b1);
        for (int k = 1; k <= HARD_TIME; k++) begin
            sec1();
            check("countdown", 16'({tens, ones}), 16'({4'((HARD_TIME - k) / 10), 4'((HARD_TIME - k) % 10)}));
        end
        check("timeout_state", 16'(gameState), 16'd0);
        sec1();
        check("no_wrap", 16'({tens, ones}), 16'h0000);

        // Reset mid-crossing, and sw6 drop after a crossing.
        do_reset(1'b0);
        press(CAT); press(CANOE); tick4(2);
        check("in_transit", 16'(canoe_crossing), 16'd1);
        btn_0_out = 1'b1;
        cycle();
        check("rst_transit", 16'({canoe_crossing, cat_crossing, cat_position, canoe_position}), 16'h0);
        do_reset(1'b0);
        press(CAT); press(CANOE); tick4(4);
        sw6 = 1'b0;
        cycle();
        check("sw6_clear", 16'({cat_position, cnt_canoe}), 16'h0);
        sw6 = 1'b1;
        cycle();

        // Randomized play against the model.
        repeat (4000) begin
            btn_0_out = ($urandom_range(0, 299) == 0);
            btn_7_out = 1'b0; btn_6_out = 1'b0; btn_5_out = 1'b0;
            r = $urandom_range(0, 9);
            if (r < 3) set_btn(r, 1'b1);
            btn_4_out = ($urandom_range(0, 5) == 0);
            clk_4Hz = 1'($urandom_range(0, 1));
            clk_1Hz = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 149) == 0) begin
                sw6 = ~sw6;
                clk_1Hz = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) sw5 = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
